// File: rtl/color_pick_ctrl.sv
// color_pick_ctrl: two-player colour pick input stage.
// Synchronizes and debounces both players' {R,G,B} buttons, then runs the
// turn/round FSM that drives the LED colour codes, round index and score.
// Optional feature macro: AUTO_RESTART_EN. When defined, the game restarts
// SHOW_CYCLES cycles after it ends. When undefined, DONE holds until reset.
module color_pick_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SHOW_CYCLES     = 64,
  parameter int unsigned ROUNDS          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_p1,
  input  logic [2:0] btn_p2,
  output logic [1:0] c_value1,
  output logic [1:0] c_value2,
  output logic [2:0] c_value,
  output logic [2:0] score,
  output logic       round_done,
  output logic       game_over
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1. The flip happens on the next count.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned TmrW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(SHOW_CYCLES - 1);
  localparam logic [2:0] LastRound = 3'(ROUNDS - 1);
  localparam logic [2:0] MaxScore  = 3'(ROUNDS);

  typedef enum logic [2:0] {
    StP1Turn,
    StP1Show,
    StP2Turn,
    StP2Show,
    StResult,
    StDone
  } state_e;

  // Bits [5:3] belong to player 1 and bits [2:0] belong to player 2, each ordered {R,G,B}.
  logic [5:0]      raw;
  logic [5:0]      sync1_q, sync2_q;
  logic [5:0]      db_q, db_d;
  logic [5:0]      db_dly_q;
  logic [CntW-1:0] cnt_q [6];
  logic [CntW-1:0] cnt_d [6];
  logic [5:0]      ev;
  logic [2:0]      ev_p1, ev_p2;

  state_e          state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [1:0]      choice1_q, choice1_d;
  logic [1:0]      choice2_q, choice2_d;
  logic [2:0]      c_value_q, c_value_d;
  logic [2:0]      score_q, score_d;
  logic [1:0]      c_value1_q, c_value1_d;
  logic [1:0]      c_value2_q, c_value2_d;
  logic            round_done_q, round_done_d;
  logic            game_over_q, game_over_d;

  assign raw = {btn_p1, btn_p2};

  // Priority R > G > B when several events arrive in the same cycle.
  function automatic logic [1:0] encode(input logic [2:0] e);
    if (e[2])      return 2'b01;
    else if (e[1]) return 2'b10;
    else if (e[0]) return 2'b11;
    else           return 2'b00;
  endfunction

  // Two-flop synchronizer, debounced levels, rise-detect delay and debounce counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Debounce: count while synced differs from debounced, and flip on the terminal count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntLast) db_d[i] = ~db_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // A press event is a single-cycle pulse on a debounced 0->1 edge. Holding a button does not repeat it.
  assign ev    = db_q & ~db_dly_q;
  assign ev_p1 = ev[5:3];
  assign ev_p2 = ev[2:0];

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StP1Turn;
      timer_q      <= '0;
      choice1_q    <= '0;
      choice2_q    <= '0;
      c_value_q    <= '0;
      score_q      <= '0;
      c_value1_q   <= '0;
      c_value2_q   <= '0;
      round_done_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      choice1_q    <= choice1_d;
      choice2_q    <= choice2_d;
      c_value_q    <= c_value_d;
      score_q      <= score_d;
      c_value1_q   <= c_value1_d;
      c_value2_q   <= c_value2_d;
      round_done_q <= round_done_d;
      game_over_q  <= game_over_d;
    end
  end

  // Next-state logic. Outputs decode the next state so they line up with state_q.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    choice1_d = choice1_q;
    choice2_d = choice2_q;
    c_value_d = c_value_q;
    score_d   = score_q;

    unique case (state_q)
      StP1Turn: begin
        if (|ev_p1) begin
          choice1_d = encode(ev_p1);
          timer_d   = '0;
          state_d   = StP1Show;
        end
      end
      StP1Show: begin
        if (timer_q == TmrLast) begin
          timer_d = '0;
          state_d = StP2Turn;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StP2Turn: begin
        if (|ev_p2) begin
          choice2_d = encode(ev_p2);
          timer_d   = '0;
          state_d   = StP2Show;
        end
      end
      StP2Show: begin
        if (timer_q == TmrLast) begin
          timer_d = '0;
          state_d = StResult;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResult: begin
        timer_d = '0;
        if ((choice1_q == choice2_q) && (score_q != MaxScore)) score_d = score_q + 3'd1;
        if (c_value_q == LastRound) begin
          state_d = StDone;
        end else begin
          c_value_d = c_value_q + 3'd1;
          state_d   = StP1Turn;
        end
      end
      StDone: begin
`ifdef AUTO_RESTART_EN
        if (timer_q == TmrLast) begin
          timer_d   = '0;
          c_value_d = '0;
          score_d   = '0;
          state_d   = StP1Turn;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`else
        state_d = StDone;
`endif
      end
      default: state_d = StP1Turn;
    endcase

    // Only one show state can be active at a time, so both codes are never non-zero together.
    c_value1_d   = (state_d == StP1Show) ? choice1_d : 2'b00;
    c_value2_d   = (state_d == StP2Show) ? choice2_d : 2'b00;
    round_done_d = (state_d == StResult);
    game_over_d  = (state_d == StDone);
  end

  assign c_value1   = c_value1_q;
  assign c_value2   = c_value2_q;
  assign c_value    = c_value_q;
  assign score      = score_q;
  assign round_done = round_done_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_color_pick_ctrl.sv
// Testbench for color_pick_ctrl, built with DEBOUNCE_CYCLES=4, SHOW_CYCLES=8 and ROUNDS=5.
// Expected shows and round results are queued when stimulus is driven.
// A negedge monitor pops and checks each one when the DUT produces it.
module tb_color_pick_ctrl;

  localparam int D = 4;
  localparam int S = 8;
  localparam int R = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_p1 = 3'b000;
  logic [2:0] btn_p2 = 3'b000;
  logic [1:0] c_value1, c_value2;
  logic [2:0] c_value, score;
  logic       round_done, game_over;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;

  // Show queue entries encode player*4 + code.
  int show_q[$];
  int round_score_q[$];
  int round_cval_q[$];

  color_pick_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SHOW_CYCLES    (S),
    .ROUNDS         (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_p1    (btn_p1),
    .btn_p2    (btn_p2),
    .c_value1  (c_value1),
    .c_value2  (c_value2),
    .c_value   (c_value),
    .score     (score),
    .round_done(round_done),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor
  logic [1:0] prev1 = 2'b00, prev2 = 2'b00;
  int len1 = 0, len2 = 0;
  bit rd_pend = 1'b0;
  int exp_show, exp_sc, exp_cv;

  always @(negedge clk) begin
    if (!rst) begin
      prev1 = 2'b00; prev2 = 2'b00; len1 = 0; len2 = 0; rd_pend = 1'b0;
    end else begin
      if (c_value1 != 2'b00 && c_value2 != 2'b00) begin
        checks++; errors++;
        $display("FAIL invariant: c_value1=%b c_value2=%b, required at least one 00",
                 c_value1, c_value2);
      end
      if (c_value1 != 2'b00 && prev1 == 2'b00) begin
        checks++;
        if (show_q.size() == 0) begin
          errors++;
          $display("FAIL show_p1: got code %b, required no show", c_value1);
        end else begin
          exp_show = show_q.pop_front();
          if (exp_show !== 4 + int'(c_value1)) begin
            errors++;
            $display("FAIL show_p1: got p1 code %0d, required player %0d code %0d",
                     c_value1, exp_show / 4, exp_show % 4);
          end
        end
      end
      if (c_value1 != 2'b00) len1++;
      else if (prev1 != 2'b00) begin
        checks++;
        if (len1 != S) begin
          errors++;
          $display("FAIL show_len_p1: got %0d cycles, required %0d", len1, S);
        end
        len1 = 0;
      end
      if (c_value2 != 2'b00 && prev2 == 2'b00) begin
        checks++;
        if (show_q.size() == 0) begin
          errors++;
          $display("FAIL show_p2: got code %b, required no show", c_value2);
        end else begin
          exp_show = show_q.pop_front();
          if (exp_show !== 8 + int'(c_value2)) begin
            errors++;
            $display("FAIL show_p2: got p2 code %0d, required player %0d code %0d",
                     c_value2, exp_show / 4, exp_show % 4);
          end
        end
      end
      if (c_value2 != 2'b00) len2++;
      else if (prev2 != 2'b00) begin
        checks++;
        if (len2 != S) begin
          errors++;
          $display("FAIL show_len_p2: got %0d cycles, required %0d", len2, S);
        end
        len2 = 0;
      end
      prev1 = c_value1;
      prev2 = c_value2;
      // Score and round index update on the cycle after the round_done pulse.
      if (rd_pend) begin
        rd_pend = 1'b0;
        checks++;
        if (round_score_q.size() == 0) begin
          errors++;
          $display("FAIL round: got unexpected round_done, required none");
        end else begin
          exp_sc = round_score_q.pop_front();
          exp_cv = round_cval_q.pop_front();
          if (int'(score) !== exp_sc || int'(c_value) !== exp_cv) begin
            errors++;
            $display("FAIL round: got score=%0d c_value=%0d, required score=%0d c_value=%0d",
                     score, c_value, exp_sc, exp_cv);
          end
        end
      end
      if (round_done) begin
        rd_count++;
        rd_pend = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0; btn_p1 = 3'b000; btn_p2 = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int player, input logic [2:0] bits, input int hold);
    @(negedge clk);
    if (player == 1) btn_p1 = bits;
    else             btn_p2 = bits;
    repeat (hold) @(negedge clk);
    btn_p1 = 3'b000; btn_p2 = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic play_round(input logic [2:0] b1, input logic [2:0] b2, input int code1,
                            input int code2, input int exp_score, input int exp_cval);
    show_q.push_back(4 + code1);
    press(1, b1, 20);
    show_q.push_back(8 + code2);
    round_score_q.push_back(exp_score);
    round_cval_q.push_back(exp_cval);
    press(2, b2, 20);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({c_value1, c_value2, c_value, score, round_done, game_over} !== 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {c_value1, c_value2, c_value, score, round_done, game_over});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bounce();
    bit seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      btn_p1 = (k % 2 == 0) ? 3'b100 : 3'b000;
      repeat (2) begin
        @(negedge clk);
        if (c_value1 != 2'b00) seen = 1'b1;
      end
    end
    btn_p1 = 3'b000;
    repeat (20) begin
      @(negedge clk);
      if (c_value1 != 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL bounce: got c_value1 non-zero, required 00");
    end
  endtask

  task automatic test_p1_show();
    int n = 0;
    bit p2_seen = 1'b0;
    show_q.push_back(4 + 1);
    @(negedge clk);
    btn_p1 = 3'b100;
    while (c_value1 == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
      if (c_value2 != 2'b00) p2_seen = 1'b1;
    end
    checks++;
    if (n < D + 2 || n > D + 4) begin
      errors++;
      $display("FAIL latency: got %0d cycles, required %0d..%0d", n, D + 2, D + 4);
    end
    repeat (20 - n) begin
      @(negedge clk);
      if (c_value2 != 2'b00) p2_seen = 1'b1;
    end
    btn_p1 = 3'b000;
    repeat (10) begin
      @(negedge clk);
      if (c_value2 != 2'b00) p2_seen = 1'b1;
    end
    checks++;
    if (p2_seen) begin
      errors++;
      $display("FAIL p1_show_c2: got c_value2 non-zero, required 00");
    end
  endtask

  task automatic test_full_round();
    int base;
    do_reset();
    base = rd_count;
    play_round(3'b010, 3'b010, 2, 2, 1, 1);
    checks++;
    if (rd_count - base != 1 || score !== 3'd1 || c_value !== 3'd1) begin
      errors++;
      $display("FAIL full_round: got pulses=%0d score=%0d c_value=%0d, required 1 1 1",
               rd_count - base, score, c_value);
    end
  endtask

  task automatic test_game();
    int base;
    bit seen = 1'b0;
    do_reset();
    base = rd_count;
    play_round(3'b100, 3'b001, 1, 3, 0, 1);
    play_round(3'b001, 3'b001, 3, 3, 1, 2);
    play_round(3'b100, 3'b010, 1, 2, 1, 3);
    play_round(3'b010, 3'b001, 2, 3, 1, 4);
    play_round(3'b010, 3'b100, 2, 1, 1, 4);
    checks++;
    if (rd_count - base != R) begin
      errors++;
      $display("FAIL game_pulses: got %0d, required %0d", rd_count - base, R);
    end
`ifndef AUTO_RESTART_EN
    checks++;
    if (game_over !== 1'b1 || c_value !== 3'd4 || score !== 3'd1) begin
      errors++;
      $display("FAIL game_end: got game_over=%b c_value=%0d score=%0d, required 1 4 1",
               game_over, c_value, score);
    end
    @(negedge clk);
    btn_p1 = 3'b100;
    repeat (20) begin
      @(negedge clk);
      if (c_value1 != 2'b00) seen = 1'b1;
    end
    btn_p1 = 3'b000;
    repeat (10) @(negedge clk);
    checks++;
    if (seen || game_over !== 1'b1) begin
      errors++;
      $display("FAIL done_ignore: got shown=%b game_over=%b, required 0 1", seen, game_over);
    end
`else
    checks++;
    if (game_over !== 1'b0 || c_value !== 3'd0 || score !== 3'd0) begin
      errors++;
      $display("FAIL auto_restart: got game_over=%b c_value=%0d score=%0d, required 0 0 0",
               game_over, c_value, score);
    end
`endif
  endtask

  task automatic test_priority();
    bit seen = 1'b0;
    do_reset();
    show_q.push_back(4 + 1);
    @(negedge clk);
    btn_p1 = 3'b111;
    btn_p2 = 3'b010;
    repeat (20) @(negedge clk);
    btn_p1 = 3'b000;
    btn_p2 = 3'b000;
    repeat (20) begin
      @(negedge clk);
      if (c_value2 != 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL p2_ignored: got c_value2 non-zero, required 00");
    end
    show_q.push_back(8 + 3);
    round_score_q.push_back(0);
    round_cval_q.push_back(1);
    press(2, 3'b001, 20);
    checks++;
    if (score !== 3'd0 || c_value !== 3'd1) begin
      errors++;
      $display("FAIL priority_round: got score=%0d c_value=%0d, required 0 1", score, c_value);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    play_round(3'b100, 3'b100, 1, 1, 1, 1);
    play_round(3'b010, 3'b001, 2, 3, 1, 2);
    show_q.push_back(4 + 3);
    press(1, 3'b001, 20);
    show_q.push_back(8 + 1);
    @(negedge clk);
    btn_p2 = 3'b100;
    while (c_value2 == 2'b00 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (c_value2 == 2'b00) begin
      errors++;
      $display("FAIL p2_show_wait: got no show within 30 cycles, required show");
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({c_value1, c_value2, c_value, score, round_done, game_over} !== 12'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b, required all zero",
               {c_value1, c_value2, c_value, score, round_done, game_over});
    end
    btn_p2 = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (c_value !== 3'd0 || score !== 3'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got c_value=%0d score=%0d game_over=%b, required 0 0 0",
               c_value, score, game_over);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_p1_show();
    test_full_round();
    test_game();
    test_priority();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (show_q.size() != 0 || round_score_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d shows %0d rounds pending, required 0 0",
               show_q.size(), round_score_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
